// File: rtl/pico_pkg.sv
// Shared types and default parameters for the PICO receive front end.
package pico_pkg;
    typedef enum logic [1:0] {IDLE, ADDR, DATA} pico_state_t;

    localparam int DEF_DATA_W      = 8;
    localparam int DEF_ADDR_W      = 8;
    localparam int DEF_TIMEOUT_CYC = 7;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_AUTO_INC    = 1;
endpackage

// File: rtl/sclk_edge_sync.sv
// Synchronises sclk and serial_in into iclk and flags sclk rising edges.
// sclk_rise and sdata are both registered so they line up cycle for cycle.
module sclk_edge_sync
    import pico_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic iclk,
    input  logic rst,
    input  logic sclk,
    input  logic serial_in,
    output logic sclk_rise,
    output logic sdata
);
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] sdata_sync;
    logic                   sclk_d;

    always_ff @(posedge iclk) begin
        if (rst) begin
            sclk_sync  <= '0;
            sdata_sync <= '0;
            sclk_d     <= 1'b0;
            sclk_rise  <= 1'b0;
            sdata      <= 1'b0;
        end else begin
            sclk_sync  <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            sdata_sync <= {sdata_sync[SYNC_STAGES-2:0], serial_in};
            sclk_d     <= sclk_sync[SYNC_STAGES-1];
            sclk_rise  <= sclk_sync[SYNC_STAGES-1] & ~sclk_d;
            sdata      <= sdata_sync[SYNC_STAGES-1];
        end
    end
endmodule

// File: rtl/pico_sync_rx.sv
// PICO receive front end: first word of a frame is the register address,
// every later word is a write strobe at an (optionally) incrementing address.
module pico_sync_rx
    import pico_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int AUTO_INC    = DEF_AUTO_INC
) (
    input  logic              iclk,
    input  logic              rst,
    input  logic              sclk,
    input  logic              serial_in,
    output logic [DATA_W-1:0] write_data,
    output logic [ADDR_W-1:0] write_addr,
    output logic              write_en,
    output logic [ADDR_W-1:0] mux_control_signal,
    output logic              frame_active,
    output logic              frame_abort
);
    localparam int CW = $clog2(DATA_W);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    pico_state_t       state, state_nxt;
    logic              sclk_rise, sdata;
    logic [DATA_W-2:0] shreg;
    logic [DATA_W-1:0] word;
    logic [CW-1:0]     bit_cnt;
    logic [TW-1:0]     to_cnt;
    logic [ADDR_W-1:0] addr;
    logic              last_bit, timeout;
    logic              addr_load, wr_fire, abort_fire;

    sclk_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .iclk      (iclk),
        .rst       (rst),
        .sclk      (sclk),
        .serial_in (serial_in),
        .sclk_rise (sclk_rise),
        .sdata     (sdata)
    );

    assign word     = {shreg, sdata};
    assign last_bit = (bit_cnt == CW'(DATA_W - 1));
    // An edge in the same cycle as the count saturating keeps the frame alive.
    assign timeout  = (to_cnt == TW'(TIMEOUT_CYC)) && (state != IDLE) && !sclk_rise;

    always_ff @(posedge iclk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (sclk_rise) state_nxt = ADDR;
            ADDR: begin
                if (sclk_rise && last_bit) state_nxt = DATA;
                else if (timeout)          state_nxt = IDLE;
            end
            DATA: if (timeout) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        frame_active = (state != IDLE);
        addr_load    = (state == ADDR) && sclk_rise && last_bit;
        wr_fire      = (state == DATA) && sclk_rise && last_bit;
        abort_fire   = timeout && (bit_cnt != '0);
    end

    assign mux_control_signal = addr;

    always_ff @(posedge iclk) begin
        if (rst) begin
            shreg       <= '0;
            bit_cnt     <= '0;
            to_cnt      <= '0;
            addr        <= '0;
            write_data  <= '0;
            write_addr  <= '0;
            write_en    <= 1'b0;
            frame_abort <= 1'b0;
        end else begin
            write_en    <= wr_fire;
            frame_abort <= abort_fire;

            if (sclk_rise) begin
                shreg   <= word[DATA_W-2:0];
                bit_cnt <= last_bit ? '0 : bit_cnt + CW'(1);
                to_cnt  <= '0;
            end else if (to_cnt != TW'(TIMEOUT_CYC)) begin
                to_cnt  <= to_cnt + TW'(1);
            end

            if (timeout) begin
                bit_cnt <= '0;
                addr    <= '0;
            end

            if (addr_load) addr <= word[ADDR_W-1:0];

            if (wr_fire) begin
                write_data <= word;
                write_addr <= addr;
                if (AUTO_INC != 0) addr <= addr + ADDR_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_pico_sync_rx.sv
// Scoreboard bench: three configurations (default, no auto-increment,
// 16-bit words with 4-bit addresses) driven by directed and random frames.
module tb_pico_sync_rx;
    logic       iclk = 1'b0;
    logic       rst;
    logic [2:0] sclk, sin;

    logic [7:0]  wd0, wa0, mux0;
    logic        we0, fa0, ab0;
    logic [7:0]  wd1, wa1, mux1;
    logic        we1, fa1, ab1;
    logic [15:0] wd2;
    logic [3:0]  wa2, mux2;
    logic        we2, fa2, ab2;

    typedef struct {
        logic [15:0] data;
        logic [7:0]  addr;
    } wr_t;

    wr_t         q0[$], q1[$], q2[$];
    logic [15:0] frm[$];
    int          n_chk = 0, n_fail = 0;
    int          exp_ab[3] = '{0, 0, 0};
    int          got_ab[3] = '{0, 0, 0};
    int          exp_ptr;

    always #5 iclk = ~iclk;

    pico_sync_rx u0 (.iclk(iclk), .rst(rst), .sclk(sclk[0]), .serial_in(sin[0]),
        .write_data(wd0), .write_addr(wa0), .write_en(we0),
        .mux_control_signal(mux0), .frame_active(fa0), .frame_abort(ab0));

    pico_sync_rx #(.AUTO_INC(0)) u1 (.iclk(iclk), .rst(rst), .sclk(sclk[1]), .serial_in(sin[1]),
        .write_data(wd1), .write_addr(wa1), .write_en(we1),
        .mux_control_signal(mux1), .frame_active(fa1), .frame_abort(ab1));

    pico_sync_rx #(.DATA_W(16), .ADDR_W(4)) u2 (.iclk(iclk), .rst(rst), .sclk(sclk[2]), .serial_in(sin[2]),
        .write_data(wd2), .write_addr(wa2), .write_en(we2),
        .mux_control_signal(mux2), .frame_active(fa2), .frame_abort(ab2));

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(int d, logic [15:0] data, logic [7:0] addr);
        wr_t e;
        e.data = data;
        e.addr = addr;
        case (d)
            0: q0.push_back(e);
            1: q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    function automatic int qsize(int d);
        case (d)
            0: return q0.size();
            1: return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic logic [7:0] get_mux(int d);
        case (d)
            0: return mux0;
            1: return mux1;
            default: return {4'h0, mux2};
        endcase
    endfunction

    function automatic logic get_fa(int d);
        case (d)
            0: return fa0;
            1: return fa1;
            default: return fa2;
        endcase
    endfunction

    task automatic mon(int d, logic [15:0] data, logic [7:0] addr);
        wr_t e;
        if (qsize(d) == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_write dut%0d: got addr %0h data %0h, none expected", d, addr, data);
        end else begin
            case (d)
                0: e = q0.pop_front();
                1: e = q1.pop_front();
                default: e = q2.pop_front();
            endcase
            check($sformatf("wr_data dut%0d", d), {16'h0, data}, {16'h0, e.data});
            check($sformatf("wr_addr dut%0d", d), {24'h0, addr}, {24'h0, e.addr});
        end
    endtask

    always @(negedge iclk) begin
        if (we0) mon(0, {8'h0, wd0}, wa0);
        if (we1) mon(1, {8'h0, wd1}, wa1);
        if (we2) mon(2, wd2, {4'h0, wa2});
        if (ab0) got_ab[0]++;
        if (ab1) got_ab[1]++;
        if (ab2) got_ab[2]++;
    end

    task automatic idle(int n);
        repeat (n) @(negedge iclk);
    endtask

    task automatic send_bit(int d, logic b);
        sclk[d] = 1'b0;
        sin[d]  = b;
        idle(3);
        sclk[d] = 1'b1;
        idle(3);
    endtask

    // Reference: address from word 0, each later word writes then bumps the pointer.
    task automatic send_frame(int d, int extra_bits, logic [15:0] extra_val);
        int dw    = (d == 2) ? 16 : 8;
        int amask = (d == 2) ? 'hF : 'hFF;
        int a     = int'(frm[0]) & amask;
        logic [15:0] w;
        for (int i = 1; i < frm.size(); i++) begin
            push(d, frm[i], 8'(a));
            if (d != 1) a = (a + 1) & amask;
        end
        if (extra_bits > 0) exp_ab[d]++;
        exp_ptr = a;
        for (int i = 0; i < frm.size(); i++) begin
            w = frm[i];
            for (int b = dw - 1; b >= 0; b--) send_bit(d, w[b]);
        end
        for (int b = extra_bits - 1; b >= 0; b--) send_bit(d, extra_val[b]);
        sclk[d] = 1'b0;
    endtask

    task automatic end_frame(int d, string tag);
        idle(3);
        check({tag, " ptr_in_frame"}, {24'h0, get_mux(d)}, exp_ptr);
        check({tag, " active_in_frame"}, {31'h0, get_fa(d)}, 1);
        idle(20);
        check({tag, " active_after_to"}, {31'h0, get_fa(d)}, 0);
        check({tag, " ptr_after_to"}, {24'h0, get_mux(d)}, 0);
        check({tag, " aborts"}, got_ab[d], exp_ab[d]);
        check({tag, " pending_writes"}, qsize(d), 0);
    endtask

    initial begin
        int n, extra;
        rst  = 1'b1;
        sclk = '0;
        sin  = '0;
        idle(4);
        check("rst write_en", {31'h0, we0}, 0);
        check("rst write_data", {24'h0, wd0}, 0);
        check("rst write_addr", {24'h0, wa0}, 0);
        check("rst mux", {24'h0, mux0}, 0);
        check("rst active", {31'h0, fa0}, 0);
        check("rst abort", {31'h0, ab0}, 0);
        check("rst wd2", {16'h0, wd2}, 0);
        rst = 1'b0;
        idle(4);

        frm = '{16'h05, 16'hA1, 16'hB2};
        send_frame(0, 0, 0);
        end_frame(0, "basic");

        frm = '{16'hFF, 16'h11, 16'h22};
        send_frame(0, 0, 0);
        end_frame(0, "wrap");
        send_frame(1, 0, 0);
        end_frame(1, "noinc");

        frm = '{16'h00, 16'h3C};
        send_frame(0, 0, 0);
        end_frame(0, "addr0");

        frm = '{16'h05};
        send_frame(0, 3, 16'h5);
        end_frame(0, "abort");

        frm = '{16'h33};
        send_frame(0, 0, 0);
        end_frame(0, "addr_only");

        // Reset lands in the middle of a data word: nothing may be written or aborted.
        for (int b = 7; b >= 0; b--) send_bit(0, 1'(8'h07 >> b));
        for (int b = 0; b < 4; b++) send_bit(0, 1'(b & 1));
        sclk[0] = 1'b0;
        idle(1);
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(20);
        check("rst_mid active", {31'h0, fa0}, 0);
        frm = '{16'h02, 16'h99};
        send_frame(0, 0, 0);
        end_frame(0, "after_rst");

        frm = '{16'hABC3, 16'h1234};
        send_frame(2, 0, 0);
        end_frame(2, "wide");

        for (int r = 0; r < 6; r++) begin
            n = $urandom_range(1, 4);
            frm = {};
            for (int i = 0; i < n; i++) frm.push_back(16'($urandom_range(0, 255)));
            extra = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 7) : 0;
            send_frame(0, extra, 16'($urandom));
            end_frame(0, $sformatf("rand0_%0d", r));
        end
        for (int r = 0; r < 3; r++) begin
            n = $urandom_range(1, 3);
            frm = {};
            for (int i = 0; i < n; i++) frm.push_back(16'($urandom));
            extra = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 15) : 0;
            send_frame(2, extra, 16'($urandom));
            end_frame(2, $sformatf("rand2_%0d", r));
        end

        idle(5);
        for (int d = 0; d < 3; d++) begin
            check($sformatf("final_pending dut%0d", d), qsize(d), 0);
            check($sformatf("final_aborts dut%0d", d), got_ab[d], exp_ab[d]);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
